// File: rtl/fetch_pkg.sv
// fetch_pkg: ARM encoding constants and branch-target helper for the fetch front end
package fetch_pkg;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] OP_B = 4'b1010;
  localparam int MAX_XLEN = 64;
  // Computed at 64 bits; callers truncate to their own XLEN, which keeps the sum modulo 2^XLEN.
  function automatic logic [MAX_XLEN-1:0] branch_target(input logic [MAX_XLEN-1:0] pc, input logic [31:0] instr);
    return pc + 64'd8 + {{38{instr[23]}}, instr[23:0], 2'b00};
  endfunction
  function automatic logic is_back_branch(input logic [31:0] instr);
    return instr[31:28] == COND_AL && instr[27:24] == OP_B && instr[23];
  endfunction
endpackage

// File: rtl/sync_flush_fifo.sv
// sync_flush_fifo: power-of-two FIFO with wrap-bit pointers and a single-cycle flush
module sync_flush_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign empty = wrPtr == rdPtr;
  assign full = wrPtr[AW-1:0] == rdPtr[AW-1:0] && wrPtr[AW] != rdPtr[AW];
  assign doPop = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign count = wrPtr - rdPtr;
  assign dout = mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (doPush && !flush && !rst) mem[wrPtr[AW-1:0]] <= din;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch PC, combinational imem drive and instruction queue toward decode
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit PREDICT_EN = 1'b0,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            deq_ready,
  output logic            deq_valid,
  output logic [31:0]     deq_instr,
  output logic [XLEN-1:0] deq_pc,
  output logic            deq_pred_taken,
  output logic [CW-1:0]   count
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            predTaken;
  } fetch_entry_t;
  logic [XLEN-1:0] fpc, nextPc;
  logic pred, push, deqFire, full, empty;
  fetch_entry_t head, tail;
  assign imem_addr = fpc;
  assign pred = PREDICT_EN && is_back_branch(imem_rdata);
  assign nextPc = pred ? XLEN'(branch_target(64'(fpc), imem_rdata)) : fpc + XLEN'(4);
  // A redirect hides the head immediately so decode cannot consume a stale entry.
  assign deq_valid = ~empty & ~redirect_valid;
  assign deqFire = deq_valid & deq_ready;
  assign push = ~redirect_valid & (~full | deqFire);
  assign tail = '{instr: imem_rdata, pc: fpc, predTaken: pred};
  assign deq_instr = head.instr;
  assign deq_pc = head.pc;
  assign deq_pred_taken = head.predTaken;
  sync_flush_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(deqFire),
    .flush(redirect_valid),
    .din(tail),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) fpc <= RESET_PC;
    else if (redirect_valid) fpc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (push) fpc <= nextPc;
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: vector table for queue/redirect/reset plus scoreboarded prediction runs
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, deq_ready;
  logic [31:0] redirect_pc;
  logic [31:0] addr1, rdata1, instr1, pc1, addr0, rdata0, instr0, pc0;
  logic valid1, pred1, valid0, pred0;
  logic [2:0] count1, count0;
  int mode = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a, input int m);
    if (m == 0 || a != 32'h40) return 32'hE0800001;
    case (m)
      1: return 32'hEAFFFFFE;
      2: return 32'h0AFFFFFE;
      default: return 32'hEA000002;
    endcase
  endfunction

  assign rdata1 = imem(addr1, mode);
  assign rdata0 = imem(addr0, mode);

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PREDICT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .imem_addr(addr1), .imem_rdata(rdata1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(valid1), .deq_instr(instr1), .deq_pc(pc1), .deq_pred_taken(pred1), .count(count1));

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PREDICT_EN(1'b0)) dutNoPred (
    .clk(clk), .rst(rst), .imem_addr(addr0), .imem_rdata(rdata0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(valid0), .deq_instr(instr0), .deq_pc(pc0), .deq_pred_taken(pred0), .count(count0));

  typedef struct {
    logic rst, redir;
    logic [31:0] rpc;
    logic rdy, v;
    logic [31:0] pc;
    logic [2:0] cnt;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[21];

  typedef struct {
    logic [31:0] pc1;
    logic p1;
    logic [31:0] pc0;
    logic p0;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_deq(input logic [31:0] p1, input logic e1, input logic [31:0] p0, input logic e0);
    sb.push_back('{pc1: p1, p1: e1, pc0: p0, p0: e0});
  endtask

  task automatic run_seq(input int m);
    exp_t e;
    @(posedge clk);
    #1 mode = m; rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h38; deq_ready = 1'b1;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (valid1) begin
        e = sb.pop_front();
        chk($sformatf("m%0d_pc", m), pc1, e.pc1);
        chk($sformatf("m%0d_pred", m), {31'b0, pred1}, {31'b0, e.p1});
        chk($sformatf("m%0d_valid_nopred", m), {31'b0, valid0}, 32'h1);
        chk($sformatf("m%0d_pc_nopred", m), pc0, e.pc0);
        chk($sformatf("m%0d_pred_nopred", m), {31'b0, pred0}, {31'b0, e.p0});
      end
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL m%0d_timeout actual=%0d required=0 entries left", m, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   3'd0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   3'd1, 32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   3'd1, 32'h8};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   3'd1, 32'hc};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hc,   3'd1, 32'h10};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3'd1, 32'h4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3'd2, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3'd3, 32'hc};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3'd4, 32'h10};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   3'd4, 32'h10};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   3'd4, 32'h10};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   3'd4, 32'h14};
    vecs[14] = '{1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0,   3'd4, 32'h14};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   3'd0, 32'h100};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 3'd1, 32'h104};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 3'd2, 32'h108};
    vecs[18] = '{1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0,   3'd3, 32'h10c};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   3'd0, 32'h300};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 3'd1, 32'h304};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1 rst = vecs[i].rst; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc; deq_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, valid1}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d_count", i), {29'b0, count1}, {29'b0, vecs[i].cnt});
      chk($sformatf("v%0d_addr", i), addr1, vecs[i].addr);
      if (vecs[i].v) chk($sformatf("v%0d_pc", i), pc1, vecs[i].pc);
    end

    expect_deq(32'h38, 1'b0, 32'h38, 1'b0);
    expect_deq(32'h3c, 1'b0, 32'h3c, 1'b0);
    expect_deq(32'h40, 1'b1, 32'h40, 1'b0);
    expect_deq(32'h40, 1'b1, 32'h44, 1'b0);
    expect_deq(32'h40, 1'b1, 32'h48, 1'b0);
    run_seq(1);
    for (int m = 2; m <= 3; m++) begin
      for (int k = 0; k < 5; k++) expect_deq(32'h38 + 4 * k, 1'b0, 32'h38 + 4 * k, 1'b0);
      run_seq(m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
